regfile_param: RTL and testbench



---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_clear_seq.sv | 62 ++++++
 rtl/regfile_param.sv | 60 ++++++
 tb/tb_regfile_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

    typedef enum logic [1:0] {RD_ZERO, RD_BYPASS, RD_ARRAY} rd_sel_e;

    // Address width for a given depth; a depth below 2 still gets one address bit.
    function automatic int rf_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Chooses the source of one read port. The zero-register rule outranks the bypass.
    function automatic rd_sel_e rd_sel(
        input logic busy,
        input logic zero_en,
        input logic bypass_en,
        input logic we,
        input logic addr_is_zero,
        input logic addr_hit
    );
        if (busy)                      return RD_ZERO;
        if (zero_en && addr_is_zero)   return RD_ZERO;
        if (bypass_en && we && addr_hit) return RD_BYPASS;
        return RD_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry to zero and holds busy until the last write.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output rf_state_e     state_o
);

    // One spare pointer bit so the last index can be compared without wrapping.
    localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

    rf_state_e   state_q, state_d;
    logic [AW:0] clr_ptr_q, clr_ptr_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        clr_we_o  = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we_o  = 1'b1;
                clr_ptr_d = clr_ptr_q + (AW+1)'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = RF_IDLE;
                    busy_d  = 1'b0;
                end
            end
            RF_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = clr_ptr_q[AW-1:0];
    assign state_o    = state_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with hardware clear on reset, optional zero register and write bypass.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reg_write,
    input  logic [AW-1:0]          write_address,
    input  logic [WIDTH-1:0]       write,
    input  logic [NREAD*AW-1:0]    read_address,
    output logic [NREAD*WIDTH-1:0] read,
    output logic                   busy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    rf_state_e        seq_state;
    logic             wr_en;

    regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .state_o    (seq_state)
    );

    // A write on a reset edge is dropped too: the clear starts on that edge.
    assign wr_en = rst_n && (seq_state == RF_IDLE) && reg_write
                   && !((ZERO_REG != 0) && (write_address == '0));

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[write_address] <= write;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] raddr;
        rd_sel_e       sel;

        assign raddr = read_address[gi*AW +: AW];
        assign sel   = rd_sel(busy, ZERO_REG != 0, BYPASS != 0, reg_write,
                              raddr == '0, raddr == write_address);
        assign read[gi*WIDTH +: WIDTH] = (sel == RD_BYPASS) ? write :
                                         (sel == RD_ARRAY)  ? mem_q[raddr] : '0;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default build, a no-bypass build and a 16x8 two-port build driven in lockstep.
module tb_regfile_param;

    localparam int W = 227;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [14:0] raddr_ab;
    logic [95:0] rd_a, rd_b;
    logic        busy_a, busy_b;
    logic [5:0]  raddr_c;
    logic [2:0]  waddr_c;
    logic [15:0] wdata_c;
    logic [31:0] rd_c;
    logic        busy_c;

    assign raddr_c = {raddr_ab[7:5], raddr_ab[2:0]};
    assign waddr_c = waddr[2:0];
    assign wdata_c = wdata[15:0];

    regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_address(waddr),
        .write(wdata), .read_address(raddr_ab), .read(rd_a), .busy(busy_a));

    regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_address(waddr),
        .write(wdata), .read_address(raddr_ab), .read(rd_b), .busy(busy_b));

    regfile_param #(.WIDTH(16), .DEPTH(8), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_address(waddr_c),
        .write(wdata_c), .read_address(raddr_c), .read(rd_c), .busy(busy_c));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] arr_ab [32];
    logic [15:0] arr_c  [8];
    bit          busy_ab_m = 1'b1;
    bit          busy_c_m  = 1'b1;
    int          left_ab   = 32;
    int          left_c    = 8;
    bit          started   = 1'b0;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic logic [31:0] exp_ab(input logic [4:0] addr, input bit bypass);
        if (busy_ab_m) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (bypass && reg_write && addr == waddr) return wdata;
        return arr_ab[addr];
    endfunction

    function automatic logic [15:0] exp_c(input logic [2:0] addr);
        if (busy_c_m) return 16'h0;
        if (addr == 3'd0) return 16'h0;
        if (reg_write && addr == waddr[2:0]) return wdata[15:0];
        return arr_c[addr];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            busy_ab_m = 1'b1; left_ab = 32;
            busy_c_m  = 1'b1; left_c  = 8;
        end else begin
            if (busy_ab_m) begin
                left_ab--;
                if (left_ab == 0) begin
                    busy_ab_m = 1'b0;
                    for (int i = 0; i < 32; i++) arr_ab[i] = 32'h0;
                end
            end else if (reg_write && waddr != 5'd0) begin
                arr_ab[waddr] = wdata;
            end
            if (busy_c_m) begin
                left_c--;
                if (left_c == 0) begin
                    busy_c_m = 1'b0;
                    for (int i = 0; i < 8; i++) arr_c[i] = 16'h0;
                end
            end else if (reg_write && waddr[2:0] != 3'd0) begin
                arr_c[waddr[2:0]] = wdata[15:0];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        logic [95:0] ea, eb;
        logic [31:0] ec;
        if (started) begin
            ea = {exp_ab(raddr_ab[14:10], 1'b1), exp_ab(raddr_ab[9:5], 1'b1), exp_ab(raddr_ab[4:0], 1'b1)};
            eb = {exp_ab(raddr_ab[14:10], 1'b0), exp_ab(raddr_ab[9:5], 1'b0), exp_ab(raddr_ab[4:0], 1'b0)};
            ec = {exp_c(raddr_ab[7:5]), exp_c(raddr_ab[2:0])};
            exp_q.push_back({busy_ab_m, busy_ab_m, busy_c_m, ea, eb, ec});
        end
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [4:0] r2);
        rst_n     = r;
        reg_write = we;
        waddr     = wa;
        wdata     = wd;
        raddr_ab  = {r2, r1, r0};
        cycle();
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 11), 5'(i + 23));
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] v;
        if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check("busy_a", {95'h0, busy_a}, {95'h0, v[226]});
            check("busy_b", {95'h0, busy_b}, {95'h0, v[225]});
            check("busy_c", {95'h0, busy_c}, {95'h0, v[224]});
            check("read_a", rd_a, v[223:128]);
            check("read_b", rd_b, v[127:32]);
            check("read_c", {64'h0, rd_c}, {64'h0, v[31:0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic       r, we;
        logic [4:0] wa, r0, r1, r2;
        rst_n = 1'b0; reg_write = 1'b0; waddr = '0; wdata = '0; raddr_ab = '0;

        // reset for two cycles, then a write to r3 on the release edge that must be dropped
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd3, 5'd3);
        read_all(40);

        // write/read with duplicate ports
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd4);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd6);

        // zero register, same cycle and after the edge
        drive(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd5);

        // bypass on/off
        drive(1'b1, 1'b1, 5'd7, 32'h11, 5'd1, 5'd2, 5'd3);
        drive(1'b1, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);

        // reset mid-clear
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, 5'(i + 1), $urandom, 5'(i), 5'(i + 1), 5'(i + 2));
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        read_all(40);

        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 149) != 0);
            we = ($urandom_range(0, 2) != 0);
            wa = 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
            drive(r, we, wa, $urandom, r0, r1, r2);
        end
        read_all(32);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
